// File: rtl/wb_read_fifo_pkg.sv
// Shared types and constants for the pull-mode Wishbone read FIFO.
package wb_read_fifo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_t;

endpackage

// File: rtl/wb_read_fifo_if.sv
// Minimal Wishbone read-path bundle. The master modport is the side that
// starts cycles and receives data. The slave modport answers them.
interface wb_read_fifo_if;
  import wb_read_fifo_pkg::*;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  stall;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] dat;

  modport master (output cyc, stb, we, input stall, ack, dat);
  modport slave  (input cyc, stb, we, output stall, ack, err, dat);

endinterface

// File: rtl/wb_fetch_ctrl.sv
// Source-side fetch sequencer: issues single Wishbone read cycles, one at a
// time, whenever prefetching is enabled and the buffer has a free slot.
//
// state      | meaning
// -----------+----------------------------------------------------------
// FETCH_IDLE | bus released; waiting for enable and a free slot
// FETCH_REQ  | cyc+stb driven; waiting for the source to stop stalling
// FETCH_WAIT | cyc held, stb dropped; waiting for ack (store strobe)
module wb_fetch_ctrl
  import wb_read_fifo_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           fetch_en_i,
  input  logic           space_i,
  wb_read_fifo_if.master m_bus,
  output logic           store_o
);

  fetch_state_t state, state_nxt;

  // State register; reset drops the bus and forgets any outstanding fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FETCH_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and bus outputs. Enable is sampled only in IDLE, so
  // dropping it mid-fetch lets the current fetch complete.
  always_comb begin
    state_nxt  = state;
    m_bus.cyc  = 1'b0;
    m_bus.stb  = 1'b0;
    store_o    = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (fetch_en_i && space_i) state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        m_bus.cyc = 1'b1;
        m_bus.stb = 1'b1;
        if (!m_bus.stall) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        m_bus.cyc = 1'b1;
        if (m_bus.ack) begin
          store_o   = 1'b1;
          state_nxt = FETCH_IDLE;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  assign m_bus.we = 1'b0;

endmodule

// File: rtl/wb_read_fifo.sv
// Pull-mode byte FIFO: prefetches from an upstream Wishbone source and
// serves the bytes to a downstream consumer through Wishbone reads.
module wb_read_fifo
  import wb_read_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fetch_en_i,
  wb_read_fifo_if.slave         s_bus,
  wb_read_fifo_if.master        m_bus,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  store;
  logic                  space;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;

  // Space is judged at fetch start; count cannot rise while that fetch is
  // outstanding, so the slot is still free when the ack arrives.
  assign space   = (count < FULL);
  assign level_o = count;

  // Writes are never stalled so they can be rejected promptly.
  assign s_bus.stall = (count == '0) && !s_bus.we;
  assign accept      = s_bus.cyc && s_bus.stb && !s_bus.stall;
  assign rd_accept   = accept && !s_bus.we;
  assign wr_accept   = accept && s_bus.we;

  wb_fetch_ctrl u_fetch (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .fetch_en_i (fetch_en_i),
    .space_i    (space),
    .m_bus      (m_bus),
    .store_o    (store)
  );

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (store) mem[wr_ptr] <= m_bus.dat;
  end

  // Pointers and occupancy; a simultaneous store and pop leaves count as is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({store, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Consumer response: the pop commits at acceptance and data/ack follow
  // one cycle later, so back-to-back reads stream at one byte per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_bus.ack <= 1'b0;
      s_bus.err <= 1'b0;
      s_bus.dat <= '0;
    end else begin
      s_bus.ack <= rd_accept;
      s_bus.err <= wr_accept;
      if (rd_accept) s_bus.dat <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_wb_read_fifo.sv
// Directed bench for wb_read_fifo: a source responder feeds a scoreboard of
// fetched bytes and a monitor pops it on every consumer ack.
module tb_wb_read_fifo;

  logic       clk;
  logic       rst_n;
  logic       fetch_en;
  logic [4:0] level;

  wb_read_fifo_if s_bus ();
  wb_read_fifo_if m_bus ();

  wb_read_fifo #(.ADDR_WIDTH(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .fetch_en_i (fetch_en),
    .s_bus      (s_bus),
    .m_bus      (m_bus),
    .level_o    (level)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_acks   = 0;
  int stall_left = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] gen_byte = 8'h40;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input int target, input int budget);
    int k = 0;
    while (level !== 5'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_level", 32'(level), 32'(target));
  endtask

  // Called at a negedge; holds a read request until n accepts or budget.
  task automatic do_reads(input int n, input int budget, output int cycles);
    int got = 0;
    cycles = 0;
    s_bus.cyc = 1'b1;
    s_bus.stb = 1'b1;
    s_bus.we  = 1'b0;
    while (got < n && cycles < budget) begin
      #1;
      if (!s_bus.stall) got++;
      @(negedge clk);
      cycles++;
    end
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    chk("reads_done", 32'(got), 32'(n));
  endtask

  // Source responder: optional stall, then ack one cycle after acceptance.
  initial begin
    logic acc_pend;
    logic [7:0] b;
    acc_pend = 1'b0;
    m_bus.stall = 1'b0;
    m_bus.ack   = 1'b0;
    m_bus.dat   = 8'h00;
    m_bus.err   = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_pend) begin
        if (src_q.size() > 0) b = src_q.pop_front();
        else begin
          b = gen_byte;
          gen_byte = gen_byte + 8'h07;
        end
        m_bus.ack = 1'b1;
        m_bus.dat = b;
        exp_q.push_back(b);
      end else begin
        m_bus.ack = 1'b0;
        m_bus.dat = 8'h00;
      end
      if (m_bus.stb && stall_left > 0) begin
        m_bus.stall = 1'b1;
        stall_left--;
      end else begin
        m_bus.stall = 1'b0;
      end
      acc_pend = m_bus.cyc && m_bus.stb && !m_bus.stall && rst_n;
    end
  end

  // Consumer monitor: every ack must carry the oldest fetched byte.
  initial begin
    forever begin
      @(negedge clk);
      if (s_bus.ack || s_bus.err)
        chk("ack_err_excl", 32'(s_bus.ack & s_bus.err), 32'd0);
      if (s_bus.ack === 1'b1) begin
        n_acks++;
        if (exp_q.size() == 0) chk("ack_unexpected", 32'(s_bus.dat), 32'hFFFF_FFFF);
        else chk("s_dat", 32'(s_bus.dat), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int c, a0, got, coinc, stalled, cyc_seen, n;
    logic p_ack, p_acc, seen;
    logic [4:0] p_lvl;

    rst_n = 1'b0;
    fetch_en = 1'b0;
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    s_bus.we  = 1'b0;
    tick(2);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_m_cyc", 32'(m_bus.cyc), 32'd0);
    chk("rst_m_stb", 32'(m_bus.stb), 32'd0);
    chk("rst_m_we", 32'(m_bus.we), 32'd0);
    chk("rst_s_ack", 32'(s_bus.ack), 32'd0);
    chk("rst_s_err", 32'(s_bus.err), 32'd0);
    chk("rst_s_dat", 32'(s_bus.dat), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Three bytes in, three back-to-back reads out.
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    fetch_en = 1'b1;
    wait_level(3, 60);
    fetch_en = 1'b0;
    tick(3);
    chk("level_three", 32'(level), 32'd3);
    chk("idle_after_three", 32'(m_bus.cyc), 32'd0);
    a0 = n_acks;
    do_reads(3, 10, c);
    chk("three_consecutive", 32'(c), 32'd3);
    tick(1);
    chk("three_acks", 32'(n_acks - a0), 32'd3);
    chk("level_empty1", 32'(level), 32'd0);

    // Fill to full, verify no fetch while full, then refill after one pop.
    fetch_en = 1'b1;
    wait_level(16, 200);
    cyc_seen = 0;
    repeat (5) begin
      tick(1);
      if (m_bus.cyc) cyc_seen++;
    end
    chk("full_no_fetch", 32'(cyc_seen), 32'd0);
    chk("full_level", 32'(level), 32'd16);
    do_reads(1, 5, c);
    chk("pop_from_full", 32'(level), 32'd15);
    tick(1);
    chk("refetch_start", 32'(m_bus.cyc), 32'd1);
    wait_level(16, 20);
    fetch_en = 1'b0;
    tick(3);
    do_reads(16, 40, c);
    chk("drain_back_to_back", 32'(c), 32'd16);
    tick(1);
    chk("level_empty2", 32'(level), 32'd0);

    // Read while empty stalls until a fetched byte lands.
    a0 = n_acks;
    stalled = 0;
    s_bus.cyc = 1'b1;
    s_bus.stb = 1'b1;
    s_bus.we  = 1'b0;
    repeat (4) begin
      #1;
      if (s_bus.stall) stalled++;
      @(negedge clk);
    end
    chk("empty_stall", 32'(stalled), 32'd4);
    chk("empty_no_ack", 32'(n_acks - a0), 32'd0);
    fetch_en = 1'b1;
    tick(1);
    fetch_en = 1'b0;
    do_reads(1, 20, c);
    chk("ack_after_accept", 32'(s_bus.ack), 32'd1);
    tick(1);

    // Source stall: strobe held through four stalled cycles, then dropped.
    stall_left = 4;
    fetch_en = 1'b1;
    stalled = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #2;
      if (m_bus.stb && m_bus.stall) stalled++;
      else if (m_bus.stb) begin
        seen = 1'b1;
        fetch_en = 1'b0;
        break;
      end
    end
    chk("stall_accept_seen", 32'(seen), 32'd1);
    chk("stall_cycles", 32'(stalled), 32'd4);
    tick(1);
    chk("wait_stb_low", 32'(m_bus.stb), 32'd0);
    chk("wait_cyc_high", 32'(m_bus.cyc), 32'd1);
    tick(2);
    chk("level_after_stall", 32'(level), 32'd1);

    // Streaming reads with concurrent fetches; pop+store leaves level alone.
    fetch_en = 1'b1;
    wait_level(8, 60);
    got = 0;
    coinc = 0;
    p_ack = 1'b0;
    p_acc = 1'b0;
    p_lvl = '0;
    s_bus.cyc = 1'b1;
    s_bus.stb = 1'b1;
    s_bus.we  = 1'b0;
    for (int k = 0; k < 120; k++) begin
      #2;
      if (p_ack && p_acc) begin
        coinc++;
        chk("pop_store_level", 32'(level), 32'(p_lvl));
      end
      p_ack = m_bus.ack;
      p_acc = !s_bus.stall;
      p_lvl = level;
      if (p_acc) got++;
      @(negedge clk);
      if (got == 24) break;
    end
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    chk("stream_reads", 32'(got), 32'd24);
    chk("stream_coincide", 32'(coinc > 0), 32'd1);
    fetch_en = 1'b0;
    tick(5);
    n = int'(level);
    if (n > 0) do_reads(n, 40, c);
    tick(1);
    chk("level_empty3", 32'(level), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Consumer write is rejected with a single err pulse.
    a0 = n_acks;
    s_bus.cyc = 1'b1;
    s_bus.stb = 1'b1;
    s_bus.we  = 1'b1;
    #1;
    chk("write_no_stall", 32'(s_bus.stall), 32'd0);
    @(negedge clk);
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    s_bus.we  = 1'b0;
    chk("write_err", 32'(s_bus.err), 32'd1);
    chk("write_no_ack", 32'(s_bus.ack), 32'd0);
    tick(1);
    chk("write_err_pulse", 32'(s_bus.err), 32'd0);
    chk("write_level", 32'(level), 32'd0);
    chk("write_no_acks", 32'(n_acks - a0), 32'd0);

    // Reset while a fetch waits for its ack; the late ack is ignored.
    fetch_en = 1'b1;
    wait_level(3, 60);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #2;
      if (m_bus.cyc && !m_bus.stb) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_wait", 32'(seen), 32'd1);
    rst_n = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(m_bus.cyc), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    #1;
    rst_n = 1'b1;
    tick(3);
    chk("late_ack_level", 32'(level), 32'd0);
    chk("late_ack_cyc", 32'(m_bus.cyc), 32'd0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
